// File: rtl/if_fetch_queue.sv
// Instruction fetch: one outstanding imem request, DEPTH-entry {pc, word} FIFO to decode,
// and EX redirect that flushes the FIFO and restarts fetch at the new address.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc, req_pc;
  logic [31:0]   fifo_code [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          req_q, accept, push, pop;

  assign accept = req_q & imem_ready;
  // A redirect kills both the incoming response and the head being consumed.
  assign push   = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign pop    = inst_ready & (count != '0) & ~redirect_valid;

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + CW'(1);
    else if (pop && !push) count_nx = count - CW'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!redirect_valid && count < FULL) state_nx = REQ;
      REQ: begin
        if (accept)              state_nx = redirect_valid ? DROP : WAIT;
        else if (redirect_valid) state_nx = IDLE;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid)        state_nx = IDLE;
          else if (count_nx < FULL)  state_nx = REQ;
          else                       state_nx = IDLE;
        end else if (redirect_valid) begin
          state_nx = DROP;
        end
      end
      DROP: if (imem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      req_q <= (state_nx == REQ);
      if (accept) req_pc <= pc;
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        if (pop)    rd_ptr <= rd_ptr + PW'(1);
        count <= count_nx;
      end
    end
  end

  // Storage needs no reset; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_code[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst_code  = inst_valid ? fifo_code[rd_ptr] : 32'h0000_0013;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed fetch/redirect/reset scenarios, a behavioural
// instruction memory, and a scoreboard monitor on the decode handshake.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic        mem_hold;
  logic        resp_pending;
  logic [31:0] resp_data;

  if_fetch_queue #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_code(inst_code), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return 32'h1300_0000 ^ a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: accepts at the edge after req&ready is seen, answers the following cycle.
  initial begin
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    resp_pending = 1'b0;
    resp_data    = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (resp_pending && !mem_hold) begin
        imem_rvalid  = 1'b1;
        imem_rdata   = resp_data;
        resp_pending = 1'b0;
      end
      if (rst_n && imem_req && imem_ready) begin
        acc_q.push_back(imem_addr);
        resp_pending = 1'b1;
        resp_data    = mem_word(imem_addr);
      end
    end
  end

  // Scoreboard monitor: a pop coinciding with a redirect is dead and not checked.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_inst: got pc %h code %h expected none", inst_pc, inst_code);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", inst_pc, e[63:32]);
          chk("sb_code", inst_code, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; mem_hold = 1'b0;

    // T1 reset
    repeat (3) tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_code", inst_code, 32'h13);
    chk("rst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t1_req", {31'h0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_code", inst_code, 32'h13);

    // T2 stream
    exp_q.push_back({32'h0, 32'h0050_0093});
    exp_q.push_back({32'h4, 32'h00A0_0113});
    inst_ready = 1'b1; imem_ready = 1'b1;
    repeat (3) tick();
    imem_ready = 1'b0;
    repeat (3) tick();
    chk("t2_drained", exp_q.size(), 32'h0);
    chk("t2_valid", {31'h0, inst_valid}, 32'h0);
    chk("t2_next_addr", imem_addr, 32'h8);

    // T3 backpressure: only DEPTH requests may be outstanding in the FIFO
    acc_q.delete();
    inst_ready = 1'b0; imem_ready = 1'b1;
    repeat (10) tick();
    chk("t3_nreq", acc_q.size(), 32'h2);
    if (acc_q.size() >= 2) begin
      chk("t3_addr0", acc_q[0], 32'h8);
      chk("t3_addr1", acc_q[1], 32'hC);
    end
    chk("t3_req_off", {31'h0, imem_req}, 32'h0);
    chk("t3_head_pc", inst_pc, 32'h8);
    exp_q.push_back({32'h8, mem_word(32'h8)});
    exp_q.push_back({32'hC, mem_word(32'hC)});
    inst_ready = 1'b1; imem_ready = 1'b0;
    repeat (4) tick();
    chk("t3_resume_req", {31'h0, imem_req}, 32'h1);
    chk("t3_resume_addr", imem_addr, 32'h10);
    chk("t3_drained", exp_q.size(), 32'h0);

    // T4 redirect while waiting
    mem_hold = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("t4_valid", {31'h0, inst_valid}, 32'h0);
    chk("t4_drop_req", {31'h0, imem_req}, 32'h0);
    mem_hold = 1'b0;
    tick();
    chk("t4_idle_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("t4_req", {31'h0, imem_req}, 32'h1);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_empty", {31'h0, inst_valid}, 32'h0);

    // T5a redirect with rvalid: no push
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t5a_valid", {31'h0, inst_valid}, 32'h0);
    chk("t5a_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("t5a_addr", imem_addr, 32'h200);

    // T5b redirect with pop
    inst_ready = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("t5b_valid", {31'h0, inst_valid}, 32'h1);
    chk("t5b_pc", inst_pc, 32'h200);
    chk("t5b_code", inst_code, mem_word(32'h200));
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("t5b_flushed", {31'h0, inst_valid}, 32'h0);
    chk("t5b_nop", inst_code, 32'h13);
    tick();
    chk("t5b_addr", imem_addr, 32'h300);

    // T5c push+pop at count 1
    inst_ready = 1'b0; imem_ready = 1'b1;
    exp_q.push_back({32'h300, mem_word(32'h300)});
    exp_q.push_back({32'h304, mem_word(32'h304)});
    repeat (3) tick();
    imem_ready = 1'b0; inst_ready = 1'b1;
    tick();
    chk("t5c_valid", {31'h0, inst_valid}, 32'h1);
    chk("t5c_pc", inst_pc, 32'h304);
    tick();
    chk("t5c_empty", {31'h0, inst_valid}, 32'h0);
    chk("t5c_drained", exp_q.size(), 32'h0);
    inst_ready = 1'b0;

    // T6 address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("t6_wrap_req", {31'h0, imem_req}, 32'h1);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk("t6_head_pc", inst_pc, 32'hFFFF_FFFC);
    chk("t6_head_code", inst_code, mem_word(32'hFFFF_FFFC));

    // T6 reset mid-WAIT
    mem_hold = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'h0, imem_req}, 32'h0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("t6_rst_code", inst_code, 32'h13);
    chk("t6_rst_pc", inst_pc, 32'h0);
    resp_pending = 1'b0; mem_hold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_req", {31'h0, imem_req}, 32'h1);
    chk("t6_post_addr", imem_addr, 32'h0);
    chk("t6_post_valid", {31'h0, inst_valid}, 32'h0);

    repeat (2) tick();
    chk("final_queue", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
